// File: rtl/led_pattern_seq_if.sv
// Control/status bundle for the LED pattern sequencer: mode inputs from the
// mode multiplexer and the registered LED drive back to it.
interface led_pattern_seq_if #(
  parameter int N_LEDS = 18
);
  logic              ENABLE;
  logic              AUTO;
  logic [2:0]        SEL;
  logic [N_LEDS-1:0] LED;
  logic [2:0]        PAT;
  logic              PAT_DONE;

  modport master (output ENABLE, AUTO, SEL, input LED, PAT, PAT_DONE);
  modport slave  (input ENABLE, AUTO, SEL, output LED, PAT, PAT_DONE);
endinterface

// File: rtl/led_pattern_seq.sv
// Width-generic LED pattern sequencer: six patterns, manual or auto-cycled,
// with pattern changes applied only at a period boundary.
module led_pattern_seq #(
  parameter int N_LEDS = 18,
  parameter int DIV    = 1,
  parameter int REPEAT = 2
) (
  input logic               PULSE,
  input logic               RESET_N,
  led_pattern_seq_if.slave  bus
);

  localparam int SW = $clog2(N_LEDS + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

  typedef enum logic [2:0] {
    PAT_WALK_UP   = 3'd0,
    PAT_WALK_DOWN = 3'd1,
    PAT_FILL      = 3'd2,
    PAT_DRAIN     = 3'd3,
    PAT_BLINK     = 3'd4,
    PAT_ALT       = 3'd5
  } pat_e;

  pat_e              pat_q, pat_d;
  logic [SW-1:0]     step_q, step_d;
  logic [DW-1:0]     div_q, div_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              done_q, done_d;
  logic              advance;

  // Index of the final step of each pattern's period.
  function automatic logic [SW-1:0] last_step(pat_e p);
    case (p)
      PAT_WALK_UP, PAT_WALK_DOWN: return SW'(N_LEDS - 1);
      PAT_FILL, PAT_DRAIN:        return SW'(N_LEDS);
      default:                    return SW'(1);
    endcase
  endfunction

  function automatic logic [N_LEDS-1:0] pattern(pat_e p, logic [SW-1:0] k);
    logic [N_LEDS-1:0] v;
    v = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (p)
        PAT_WALK_UP:   v[i] = (i == int'(k));
        PAT_WALK_DOWN: v[i] = (i == N_LEDS - 1 - int'(k));
        PAT_FILL:      v[i] = (i < int'(k));
        PAT_DRAIN:     v[i] = (i < N_LEDS - int'(k));
        PAT_BLINK:     v[i] = (k == '0);
        PAT_ALT:       v[i] = (i[0] == k[0]);
        default:       v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path through
  // the branches can leave a signal unassigned and infer a latch.
  always_comb begin
    div_d   = div_q;
    step_d  = step_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (bus.ENABLE) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        advance = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (advance) begin
      if (step_q == last_step(pat_q)) begin
        // Boundary: the only point where SEL and AUTO are looked at.
        done_d = 1'b1;
        step_d = '0;
        if (!bus.AUTO) begin
          if (bus.SEL <= 3'd5) pat_d = pat_e'(bus.SEL);
          rep_d = '0;
        end else if (rep_q == REP_LAST) begin
          pat_d = (pat_q == PAT_ALT) ? PAT_WALK_UP : pat_e'(pat_q + 3'd1);
          rep_d = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end

    // LED is registered from next state so it always matches PAT/STEP.
    led_d = pattern(pat_d, step_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PULSE or negedge RESET_N) begin
    if (!RESET_N) begin
      pat_q  <= PAT_WALK_UP;
      step_q <= '0;
      div_q  <= '0;
      rep_q  <= '0;
      led_q  <= N_LEDS'(1);
      done_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      step_q <= step_d;
      div_q  <= div_d;
      rep_q  <= rep_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign bus.LED      = led_q;
  assign bus.PAT      = pat_q;
  assign bus.PAT_DONE = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: N_LEDS=18 at DIV=1 for the pattern and
// mode behaviour, and a DIV=3 instance for prescaling and freeze.
module tb_led_pattern_seq;

  logic PULSE;
  logic RESET_N;

  led_pattern_seq_if #(.N_LEDS(18)) bus0 ();
  led_pattern_seq_if #(.N_LEDS(18)) bus1 ();

  led_pattern_seq #(.N_LEDS(18), .DIV(1), .REPEAT(2)) u_dut (
    .PULSE   (PULSE),
    .RESET_N (RESET_N),
    .bus     (bus0)
  );

  led_pattern_seq #(.N_LEDS(18), .DIV(3), .REPEAT(2)) u_dut_div3 (
    .PULSE   (PULSE),
    .RESET_N (RESET_N),
    .bus     (bus1)
  );

  typedef struct {
    logic        en;
    logic        auto_m;
    logic [2:0]  sel;
    logic [17:0] led;
    logic [2:0]  pat;
    logic        done;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial begin
    PULSE = 1'b0;
    forever #5 PULSE = ~PULSE;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PULSE);
    #1;
  endtask

  task automatic check_u0(input string name, input logic [17:0] led,
                          input logic [2:0] pat, input logic done);
    check({name, ".led"},  32'(bus0.LED),      32'(led));
    check({name, ".pat"},  32'(bus0.PAT),      32'(pat));
    check({name, ".done"}, 32'(bus0.PAT_DONE), 32'(done));
  endtask

  function automatic vec_t mk(input logic en, input logic auto_m, input logic [2:0] sel,
                              input logic [17:0] led, input logic [2:0] pat, input logic done);
    vec_t v;
    v.en = en; v.auto_m = auto_m; v.sel = sel;
    v.led = led; v.pat = pat; v.done = done;
    return v;
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      bus0.ENABLE = tbl[i].en;
      bus0.AUTO   = tbl[i].auto_m;
      bus0.SEL    = tbl[i].sel;
      tick();
      check_u0($sformatf("%s[%0d]", tag, i), tbl[i].led, tbl[i].pat, tbl[i].done);
    end
  endtask

  initial begin
    logic [17:0] one;
    logic [18:0] fill;
    one = 18'd1;

    RESET_N     = 1'b0;
    bus0.ENABLE = 1'b0; bus0.AUTO = 1'b0; bus0.SEL = 3'd0;
    bus1.ENABLE = 1'b0; bus1.AUTO = 1'b0; bus1.SEL = 3'd0;
    repeat (2) tick();
    check_u0("reset", 18'h00001, 3'd0, 1'b0);
    check("reset.div3.led", 32'(bus1.LED), 32'h1);

    // P0 walk, first period straight after reset release.
    RESET_N     = 1'b1;
    bus0.ENABLE = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("p0_walk[%0d].led", k), 32'(bus0.LED), 32'(one << k));
    end
    check_u0("p0_last", 18'h20000, 3'd0, 1'b0);
    tick();
    check_u0("p0_wrap", 18'h00001, 3'd0, 1'b1);

    // SEL=4 requested mid-period: P0 must finish before switching.
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 5) bus0.SEL = 3'd4;
    end
    check_u0("p0_no_truncate", 18'h20000, 3'd0, 1'b0);
    tick();
    check_u0("switch_to_p4", 18'h3FFFF, 3'd4, 1'b1);

    tbl.delete();
    tbl.push_back(mk(1'b1, 1'b0, 3'd4, 18'h00000, 3'd4, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'd4, 18'h3FFFF, 3'd4, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 18'h00000, 3'd4, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'd2, 18'h00000, 3'd2, 1'b1));
    run_table("manual");

    // Invalid select during P2: pattern must restart as P2.
    bus0.SEL = 3'd7;
    for (int k = 1; k <= 18; k++) begin
      tick();
      fill = (19'd1 << k) - 19'd1;
      check($sformatf("p2_fill[%0d].led", k), 32'(bus0.LED), 32'(fill[17:0]));
    end
    tick();
    check_u0("p2_invalid_sel", 18'h00000, 3'd2, 1'b1);

    bus0.SEL = 3'd4;
    repeat (18) tick();
    tick();
    check_u0("enter_p4", 18'h3FFFF, 3'd4, 1'b1);

    // Auto mode, REPEAT=2: P4 twice more then P5 twice then P0; SEL ignored.
    tbl.delete();
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h00000, 3'd4, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h3FFFF, 3'd4, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h00000, 3'd4, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h15555, 3'd5, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h2AAAA, 3'd5, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h15555, 3'd5, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h2AAAA, 3'd5, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd1, 18'h00001, 3'd0, 1'b1));
    run_table("auto");

    // Auto through P0, P1, P2 into the second P3 period, step 7.
    for (int n = 1; n <= 136; n++) begin
      tick();
      if (n == 36)  check_u0("auto_p1",  18'h20000, 3'd1, 1'b1);
      if (n == 72)  check_u0("auto_p2",  18'h00000, 3'd2, 1'b1);
      if (n == 110) check_u0("auto_p3",  18'h3FFFF, 3'd3, 1'b1);
      if (n == 136) check_u0("p3_step7", 18'h007FF, 3'd3, 1'b0);
    end

    // Asynchronous reset between edges.
    #3;
    RESET_N = 1'b0;
    #1;
    check_u0("async_reset", 18'h00001, 3'd0, 1'b0);
    #2;
    RESET_N = 1'b1;
    tick();
    check_u0("post_reset_step1", 18'h00002, 3'd0, 1'b0);
    repeat (17) tick();
    check_u0("post_reset_rep0", 18'h00001, 3'd0, 1'b1);
    repeat (18) tick();
    check_u0("post_reset_rep1", 18'h20000, 3'd1, 1'b1);

    // Prescaler DIV=3 and freeze with ENABLE=0 mid-phase.
    bus1.ENABLE = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("div3[%0d].led", e), 32'(bus1.LED), 32'(one << (e / 3)));
    end
    bus1.ENABLE = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("freeze[%0d].led", e),  32'(bus1.LED),      32'h4);
      check($sformatf("freeze[%0d].pat", e),  32'(bus1.PAT),      32'h0);
      check($sformatf("freeze[%0d].done", e), 32'(bus1.PAT_DONE), 32'h0);
    end
    bus1.ENABLE = 1'b1;
    tick();
    check("resume_phase.led", 32'(bus1.LED), 32'h4);
    tick();
    check("resume_adv.led", 32'(bus1.LED), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer, the successor to the switch-selected LED mode. It drives an N_LEDS-wide LED bank with six built-in, width-generic patterns. In manual mode a switch selects the pattern; in auto mode the patterns cycle with a programmable repeat count. Pattern changes take effect only at a pattern boundary, so no pattern is ever truncated. The block sits under the mode multiplexer and is clocked by the divided clock PULSE.

## Interface
- N_LEDS, 18, LED bank width (≥4)
- DIV, 1, enabled PULSE cycles per pattern step (≥1)
- REPEAT, 2, complete periods of each pattern before auto-advance (≥1)
- PULSE  in  1  divided clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  1 = run, 0 = freeze all state (mode-select gate)
- AUTO  in  1  0 = manual (SEL), 1 = auto cycle
- SEL  in  3  requested pattern in manual mode, valid 0..5
- LED  out  N_LEDS  registered LED drive
- PAT  out  3  pattern currently displayed
- PAT_DONE  out  1  one-cycle pulse on the final step advance of each period

## Operation
- State registers: PAT (3b), STEP (0..period-1), prescaler DIV_CNT (0..DIV-1), repeat counter REP_CNT (0..REPEAT-1).
- Step k patterns, bit 0 = LSB:
  - P0, period N: only bit k set.
  - P1, period N: only bit N-1-k set.
  - P2 fill, period N+1: low k bits set.
  - P3 drain, period N+1: low N-k bits set.
  - P4 blink, period 2: k=0 all on, k=1 all off.
  - P5 alternate, period 2: k=0 even-index bits set, k=1 odd-index bits set.
- Advance: when ENABLE=1, DIV_CNT increments each cycle. When DIV_CNT=DIV-1 it wraps to 0 and a step advance occurs.
- On advance with STEP < period-1: STEP+1, PAT unchanged.
- On advance with STEP = period-1 (boundary): PAT_DONE=1 that cycle, STEP←0, next PAT selected as follows.
  - Manual: PAT←SEL if SEL≤5, else PAT unchanged. REP_CNT←0.
  - Auto: if REP_CNT=REPEAT-1, then PAT←(PAT=5 ? 0 : PAT+1) and REP_CNT←0. Otherwise REP_CNT+1.
- SEL and AUTO are sampled only at a boundary. Changes between boundaries have no effect.
- Switching from auto to manual, or manual to auto, takes effect at the next boundary. REP_CNT restarts from 0 whenever PAT changes.
- ENABLE=0: PAT, STEP, DIV_CNT, REP_CNT and LED hold. PAT_DONE=0.
- LED is registered and always equals pattern(PAT, STEP) of the same registered state. It is updated on the same edge as PAT/STEP; no combinational path from inputs to LED.

## Timing
- Reset (RESET_N low, asynchronous, any time including mid-period): PAT=0, STEP=0, DIV_CNT=0, REP_CNT=0, LED={N_LEDS{0}} with bit0=1, PAT_DONE=0.
- First edge after RESET_N release with ENABLE=1 and DIV=1 is an advance: LED shows P0 step 1.
- Step rate: one advance per DIV enabled cycles. Pattern latency from a SEL change is at most one full period of the current pattern.
- PAT_DONE is registered and asserted in the cycle after the boundary edge. It coincides with LED showing step 0 of the new pattern.
- Period widths use N_LEDS; the STEP counter is sized to hold N_LEDS.

## Test plan
- Reset/P0 (N=18, DIV=1): hold RESET_N=0 → LED=18'h00001, PAT=0. Release with ENABLE=1 → after 17 edges LED=18'h20000; 18th edge → LED=18'h00001, PAT_DONE=1 for one cycle.
- Manual boundary switch: SEL=4 while P0 is at step 5 → P0 continues to 18'h20000. Next edge → PAT=4, LED=18'h3FFFF, then 18'h00000, 18'h3FFFF…
- Invalid select: SEL=7 during P2 → at boundary PAT stays 2, LED restarts at 18'h00000. Fill reaches 18'h3FFFF at step 18.
- Auto (REPEAT=2) from P4 → LED 3FFFF, 00000, 3FFFF, 00000 with two PAT_DONE pulses → PAT=5, LED=18'h15555, then 18'h2AAAA. After P5 ×2 → PAT=0.
- Freeze/prescale (DIV=3): LED changes every 3rd edge. Drop ENABLE for 10 cycles mid-pattern → LED, PAT, PAT_DONE frozen; resumes from the same DIV_CNT phase.
- Reset mid-operation: assert RESET_N=0 asynchronously during P3 step 7 in auto mode → LED=18'h00001, PAT=0 immediately, without waiting for a clock edge. After release, the sequence restarts at P0 with REP_CNT=0.
